// File: rtl/xbus_arbiter.sv
// Two-master round-robin arbiter for the picoVersat data bus.
// Grants one master per access, supports bounded locked bursts and registers read data.
module xbus_arbiter #(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_lock,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_lock,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              s_sel,
    output logic              s_we,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wdata,
    input  logic [DATA_W-1:0] s_rdata,
    output logic              owner,
    output logic              busy
);

    localparam int CNT_W = $clog2(MAX_BURST) + 1;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             owner_r;
    logic             last_owner;
    logic [CNT_W-1:0] burst_cnt;

    logic             any_req;
    logic             winner;
    logic             own_req;
    logic             own_lock;
    logic             own_we;
    logic             burst_room;

    always_comb begin
        own_req  = owner_r ? m1_req  : m0_req;
        own_lock = owner_r ? m1_lock : m0_lock;
        own_we   = owner_r ? m1_we   : m0_we;
    end

    // On a tie the master that did not own the bus last time wins.
    always_comb begin
        any_req = m0_req | m1_req;
        if (m0_req && m1_req) begin
            winner = ~last_owner;
        end else begin
            winner = m1_req;
        end
    end

    assign burst_room = (burst_cnt < MAX_CNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                state_nxt = DONE;
            end
            DONE: begin
                if (own_lock && burst_room) begin
                    state_nxt = HOLD;
                end else begin
                    state_nxt = IDLE;
                end
            end
            HOLD: begin
                if (own_req) begin
                    state_nxt = ACCESS;
                end else if (!own_lock) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // burst_cnt restarts only on a fresh grant so a held tenure keeps counting.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_r    <= 1'b0;
            last_owner <= 1'b1;
            burst_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner_r   <= winner;
                        burst_cnt <= '0;
                    end
                end
                ACCESS: begin
                    burst_cnt <= burst_cnt + CNT_W'(1);
                end
                DONE: begin
                    last_owner <= owner_r;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m0_rdata <= '0;
            m1_rdata <= '0;
        end else if (state == ACCESS && !own_we) begin
            if (owner_r) begin
                m1_rdata <= s_rdata;
            end else begin
                m0_rdata <= s_rdata;
            end
        end
    end

    always_comb begin
        s_sel   = (state == ACCESS);
        s_we    = (state == ACCESS) && own_we;
        s_addr  = owner_r ? m1_addr  : m0_addr;
        s_wdata = owner_r ? m1_wdata : m0_wdata;
        m0_ack  = (state == DONE) && !owner_r;
        m1_ack  = (state == DONE) && owner_r;
        owner   = owner_r;
        busy    = (state != IDLE);
    end

endmodule

// File: tb/tb_xbus_arbiter.sv
// Testbench for xbus_arbiter: directed protocol scenarios plus randomized traffic,
// checked every cycle against a transaction-timing reference model.
module tb_xbus_arbiter;

    localparam int ADDR_W    = 12;
    localparam int DATA_W    = 32;
    localparam int MAX_BURST = 4;

    typedef struct packed {
        logic              we;
        logic              lock;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [3:0]        gap;
    } txn_t;

    logic              clk;
    logic              rst;
    logic              m0_req, m0_lock, m0_we;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_ack;
    logic [DATA_W-1:0] m0_rdata;
    logic              m1_req, m1_lock, m1_we;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_ack;
    logic [DATA_W-1:0] m1_rdata;
    logic              s_sel, s_we;
    logic [ADDR_W-1:0] s_addr;
    logic [DATA_W-1:0] s_wdata;
    logic [DATA_W-1:0] s_rdata;
    logic              owner;
    logic              busy;

    xbus_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MAX_BURST(MAX_BURST)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .m0_req  (m0_req),
        .m0_lock (m0_lock),
        .m0_we   (m0_we),
        .m0_addr (m0_addr),
        .m0_wdata(m0_wdata),
        .m0_ack  (m0_ack),
        .m0_rdata(m0_rdata),
        .m1_req  (m1_req),
        .m1_lock (m1_lock),
        .m1_we   (m1_we),
        .m1_addr (m1_addr),
        .m1_wdata(m1_wdata),
        .m1_ack  (m1_ack),
        .m1_rdata(m1_rdata),
        .s_sel   (s_sel),
        .s_we    (s_we),
        .s_addr  (s_addr),
        .s_wdata (s_wdata),
        .s_rdata (s_rdata),
        .owner   (owner),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Decoder stand-in: combinational read, written from the bus during write accesses.
    logic [DATA_W-1:0] mem     [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] ref_mem [0:(1<<ADDR_W)-1];
    assign s_rdata = mem[s_addr];

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // Reference model: times (cycle numbers) of the next arbitration, access and ack.
    int   arb_cyc, acc_cyc, done_cyc;
    bit   held;
    int   cnt;
    bit   last_m, cur_own;
    txn_t acc_t;
    logic [DATA_W-1:0] rdata_ref [2];

    // Master agents
    txn_t q0[$];
    txn_t q1[$];
    txn_t cur [2];
    bit   cur_valid [2];
    bit   retire [2];
    int   gap_left [2];

    int   ack_log[$];
    int   ack_cyc_log[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic txn_t mk(input logic we, input logic lock, input logic [ADDR_W-1:0] addr,
                                input logic [DATA_W-1:0] wdata, input int gap);
        txn_t t;
        t.we = we; t.lock = lock; t.addr = addr; t.wdata = wdata; t.gap = 4'(gap);
        return t;
    endfunction

    task automatic push(input int m, input txn_t t);
        if (m == 0) q0.push_back(t);
        else        q1.push_back(t);
    endtask

    task automatic apply_inputs();
        bit a0, a1;
        a0 = cur_valid[0] && gap_left[0] == 0;
        a1 = cur_valid[1] && gap_left[1] == 0;
        m0_req = a0; m0_lock = a0 & cur[0].lock; m0_we = cur[0].we;
        m0_addr = cur[0].addr; m0_wdata = cur[0].wdata;
        m1_req = a1; m1_lock = a1 & cur[1].lock; m1_we = cur[1].we;
        m1_addr = cur[1].addr; m1_wdata = cur[1].wdata;
    endtask

    task automatic drive_agents();
        for (int m = 0; m < 2; m++) begin
            if (retire[m]) begin
                cur_valid[m] = 1'b0;
                retire[m]    = 1'b0;
            end
            if (!cur_valid[m] && ((m == 0) ? q0.size() : q1.size()) > 0) begin
                cur[m]       = (m == 0) ? q0.pop_front() : q1.pop_front();
                gap_left[m]  = int'(cur[m].gap);
                cur_valid[m] = 1'b1;
            end else if (cur_valid[m] && gap_left[m] > 0) begin
                gap_left[m]--;
            end
        end
        apply_inputs();
    endtask

    task automatic clear_agents();
        q0.delete();
        q1.delete();
        for (int m = 0; m < 2; m++) begin
            cur[m] = '0; cur_valid[m] = 1'b0; retire[m] = 1'b0; gap_left[m] = 0;
        end
        apply_inputs();
    endtask

    task automatic model_reset();
        held = 1'b0; cnt = 0; last_m = 1'b1; cur_own = 1'b0;
        acc_cyc = -1; done_cyc = -1; arb_cyc = cyc + 1;
        rdata_ref[0] = '0; rdata_ref[1] = '0;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic grant(input bit w);
        cur_own  = w;
        acc_t    = cur[w];
        acc_cyc  = cyc + 1;
        done_cyc = cyc + 2;
        arb_cyc  = -1;
    endtask

    task automatic cycle_step();
        bit exp_sel;
        bit r0, r1, own_r, own_l;
        adv();
        drive_agents();
        #1;
        exp_sel = (cyc == acc_cyc);
        check("s_sel", s_sel, exp_sel);
        check("s_we", s_we, exp_sel && acc_t.we);
        check("m0_ack", m0_ack, cyc == done_cyc && cur_own == 1'b0);
        check("m1_ack", m1_ack, cyc == done_cyc && cur_own == 1'b1);
        check("busy", busy, !(cyc == arb_cyc && !held));
        check("owner", owner, cur_own);
        check("m0_rdata", m0_rdata, rdata_ref[0]);
        check("m1_rdata", m1_rdata, rdata_ref[1]);
        if (exp_sel) begin
            check("s_addr", s_addr, acc_t.addr);
            check("s_wdata", s_wdata, acc_t.wdata);
        end
        if (m0_ack) begin ack_log.push_back(0); ack_cyc_log.push_back(cyc); end
        if (m1_ack) begin ack_log.push_back(1); ack_cyc_log.push_back(cyc); end
        if (s_sel && s_we) mem[s_addr] = s_wdata;

        r0 = m0_req; r1 = m1_req;
        own_r = cur_own ? m1_req : m0_req;
        own_l = cur_own ? m1_lock : m0_lock;
        if (cyc == acc_cyc) begin
            if (acc_t.we) ref_mem[acc_t.addr] = acc_t.wdata;
            else          rdata_ref[cur_own] = ref_mem[acc_t.addr];
        end
        if (cyc == done_cyc) begin
            retire[cur_own] = 1'b1;
            last_m  = cur_own;
            held    = own_l && (cnt < MAX_BURST);
            arb_cyc = cyc + 1;
        end else if (cyc == arb_cyc) begin
            if (held) begin
                if (own_r) begin
                    cnt++;
                    grant(cur_own);
                end else begin
                    if (!own_l) held = 1'b0;
                    arb_cyc = cyc + 1;
                end
            end else if (r0 || r1) begin
                cnt = 1;
                grant((r0 && r1) ? !last_m : r1);
            end else begin
                arb_cyc = cyc + 1;
            end
        end
    endtask

    function automatic bit is_idle();
        return q0.size() == 0 && q1.size() == 0 && !cur_valid[0] && !cur_valid[1]
               && cyc > done_cyc && !held;
    endfunction

    task automatic run(input int budget);
        int n = 0;
        ack_log.delete();
        ack_cyc_log.delete();
        do begin
            cycle_step();
            n++;
        end while (!is_idle() && n < budget);
        check("drain_done", is_idle(), 1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_agents();
        for (int i = 0; i < 2; i++) begin
            adv();
            check("rst_s_sel", s_sel, 1'b0);
            check("rst_s_we", s_we, 1'b0);
            check("rst_m0_ack", m0_ack, 1'b0);
            check("rst_m1_ack", m1_ack, 1'b0);
            check("rst_busy", busy, 1'b0);
            check("rst_owner", owner, 1'b0);
            check("rst_m0_rdata", m0_rdata, 32'h0);
            check("rst_m1_rdata", m1_rdata, 32'h0);
        end
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int n;
        rst = 1'b1;
        for (int i = 0; i < (1 << ADDR_W); i++) begin
            mem[i]     = i * 32'h9E37_79B1;
            ref_mem[i] = i * 32'h9E37_79B1;
        end
        mem[12'h010]     = 32'hDEAD_BEEF;
        ref_mem[12'h010] = 32'hDEAD_BEEF;
        clear_agents();
        do_reset();

        // Single read by m0
        push(0, mk(1'b0, 1'b0, 12'h010, 32'h0, 0));
        run(50);
        check("single_ack_count", ack_log.size(), 1);
        if (ack_log.size() == 1) check("single_master", ack_log[0], 0);
        check("single_rdata", m0_rdata, 32'hDEAD_BEEF);

        // Tie fairness from reset: strict alternation, one ack every 3 cycles
        do_reset();
        for (int i = 0; i < 4; i++) begin
            push(0, mk(1'b0, 1'b0, 12'(12'h020 + i), 32'h0, 0));
            push(1, mk(1'b0, 1'b0, 12'(12'h030 + i), 32'h0, 0));
        end
        run(200);
        check("tie_ack_count", ack_log.size(), 8);
        for (int i = 0; i < ack_log.size(); i++) begin
            check("tie_order", ack_log[i], i % 2);
            if (i > 0) check("tie_period", ack_cyc_log[i] - ack_cyc_log[i-1], 3);
        end

        // Locked burst by m1, capped at MAX_BURST, with m0 waiting
        for (int i = 0; i < 6; i++)
            push(1, mk(1'b1, 1'b1, 12'(12'h100 + i), 32'(i + 1), 0));
        push(0, mk(1'b0, 1'b0, 12'h010, 32'h0, 1));
        run(300);
        check("burst_ack_count", ack_log.size(), 7);
        for (int i = 0; i < ack_log.size(); i++)
            check("burst_order", ack_log[i], (i == 4) ? 0 : 1);
        for (int i = 0; i < 6; i++)
            check("burst_mem", mem[12'h100 + i], 32'(i + 1));

        // Lock release in HOLD hands the bus to the pending m1 immediately
        push(0, mk(1'b0, 1'b1, 12'h011, 32'h0, 0));
        push(1, mk(1'b0, 1'b0, 12'h012, 32'h0, 1));
        run(100);
        check("release_ack_count", ack_log.size(), 2);
        if (ack_log.size() == 2) begin
            check("release_first", ack_log[0], 0);
            check("release_second", ack_log[1], 1);
            check("release_gap", ack_cyc_log[1] - ack_cyc_log[0], 4);
        end

        // Write by m1 must not disturb its read data
        push(1, mk(1'b0, 1'b0, 12'h010, 32'h0, 0));
        push(1, mk(1'b1, 1'b0, 12'h040, 32'h55, 0));
        run(100);
        check("write_keeps_rdata", m1_rdata, 32'hDEAD_BEEF);
        check("write_mem", mem[12'h040], 32'h55);

        // Reset during ACCESS abandons the access
        push(0, mk(1'b0, 1'b0, 12'h013, 32'h0, 0));
        n = 0;
        do begin
            cycle_step();
            n++;
        end while (cyc != acc_cyc && n < 20);
        check("abort_reached_access", s_sel, 1'b1);
        do_reset();
        push(0, mk(1'b0, 1'b0, 12'h014, 32'h0, 0));
        push(1, mk(1'b0, 1'b0, 12'h015, 32'h0, 0));
        run(100);
        check("post_rst_ack_count", ack_log.size(), 2);
        if (ack_log.size() == 2) check("post_rst_first", ack_log[0], 0);

        // Randomized traffic
        for (int i = 0; i < 30; i++) begin
            for (int m = 0; m < 2; m++)
                push(m, mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                           12'(12'h200 + $urandom_range(0, 15)), $urandom,
                           $urandom_range(0, 3)));
        end
        run(3000);
        check("random_ack_count", ack_log.size(), 60);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/xbus_arbiter.md
# xbus_arbiter

Two-master arbiter for the picoVersat memory-mapped data bus: the CPU data port (master 0) and an external/DMA master (master 1) share the single address/select/data path that feeds the address decoder. It grants one master per transaction with round-robin fairness, supports locked bursts bounded by a maximum length, registers read data and returns a one-cycle acknowledge. It sits between the masters and the decoder's `addr`/`sel`/`data_to_rd` ports.

## Interface

Parameters:
- `ADDR_W`, 12: bus address width.
- `DATA_W`, 32: bus data width.
- `MAX_BURST`, 8: maximum accesses per locked tenure; must be at least 1.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `m0_req`, `m1_req`  in  1  access request; held high until the master's ack.
- `m0_lock`, `m1_lock`  in  1  keep ownership for the next access (burst).
- `m0_we`, `m1_we`  in  1  1 = write, 0 = read.
- `m0_addr`, `m1_addr`  in  ADDR_W  access address.
- `m0_wdata`, `m1_wdata`  in  DATA_W  write data.
- `m0_ack`, `m1_ack`  out  1  one-cycle completion pulse.
- `m0_rdata`, `m1_rdata`  out  DATA_W  registered read data; valid while ack is high, held until that master's next ack.
- `s_sel`  out  1  bus select to the decoder.
- `s_we`  out  1  bus write enable.
- `s_addr`  out  ADDR_W  bus address.
- `s_wdata`  out  DATA_W  bus write data.
- `s_rdata`  in  DATA_W  decoder read data; sampled at the end of the ACCESS cycle.
- `owner`  out  1  current/last granted master.
- `busy`  out  1  high in any state other than IDLE.

## Operation

- Registered state: `state` ∈ {IDLE, ACCESS, DONE, HOLD}, `owner`, `last_owner`, `burst_cnt` (width clog2(MAX_BURST)+1).
- Reset values:
  - state=IDLE, owner=0, last_owner=1 (so m0 wins the first tie), burst_cnt=0.
  - Both acks 0, both rdata 0.
  - s_sel=0, s_we=0; busy=0.
- Bus mux: `s_addr`/`s_wdata` always carry the `owner` master's addr/wdata. `s_sel`=1 and `s_we`=owner's we only in ACCESS; both are 0 in every other state.
- IDLE:
  - One requester: grant it.
  - Both requesting: grant `!last_owner`.
  - On a grant: owner←winner, burst_cnt←0, go to ACCESS.
  - No request: stay in IDLE.
- ACCESS: exactly one cycle.
  - If we=0, the owner's rdata←s_rdata; on a write, rdata is unchanged.
  - burst_cnt←burst_cnt+1; owner's ack←1; go to DONE.
- DONE:
  - Owner's ack is high this cycle only; last_owner←owner.
  - If owner's lock=1 and burst_cnt<MAX_BURST, go to HOLD; otherwise go to IDLE.
- HOLD: the other master is excluded.
  - Owner req=1: go to ACCESS (burst_cnt keeps counting).
  - Owner lock=0 and req=0: go to IDLE.
  - Lock high with no req: wait indefinitely.
- Burst bound: after MAX_BURST accesses the tenure ends regardless of lock. Arbitration in IDLE then favours the other master, because last_owner equals the previous owner.
- A master that drops req during ACCESS violates the protocol; the access still completes and ack is still issued.
- The non-owner's ack is always 0. At most one ack is high in any cycle.

## Timing

- Unlocked access: req sampled in IDLE at cycle N; ACCESS (s_sel=1) at N+1; ack and rdata valid at N+2; re-arbitration at N+3. Period is 3 cycles per access.
- Locked access: DONE at N+2, HOLD at N+3; if req is high at N+3, ACCESS at N+4.
- The master may change addr/we/wdata, or drop req, from the cycle after its ack. Req must be low, or carry a new request, when HOLD or IDLE samples it.
- `rst` during any state: the next cycle is IDLE with all outputs at reset values. An in-flight ACCESS is abandoned: no ack, rdata not updated.
- busy=1 from the cycle after the grant edge until the return to IDLE.

## Test plan

- Single read: m0_req=1, we=0, addr=0x010; decoder returns 0xDEADBEEF. Required: s_sel=1 at N+1 with s_addr=0x010; m0_ack=1 at N+2 with m0_rdata=0xDEADBEEF; m1_ack stays 0.
- Tie fairness: both masters request continuously, no lock. Required: grants alternate m0, m1, m0, m1, starting with m0 after reset; each ack is 3 cycles after the previous ack.
- Locked burst: MAX_BURST=4; m1 writes 0x1..0x6 to addr 0x100..0x105 with lock=1 while m0_req=1. Required: 4 consecutive m1 accesses (0x100..0x103), then an m0 access, then m1 resumes.
- Lock release: m0 issues lock=1, then drops both req and lock while in HOLD. Required: IDLE on the next cycle; a pending m1_req is granted immediately.
- Write gating: m1 write with we=1, wdata=0x55. Required: s_we=1 only during ACCESS; m1_rdata keeps its previous value.
- Reset mid-access: assert rst in the ACCESS cycle. Required: the next cycle has s_sel=0, no ack, busy=0, and the first tie after reset goes to m0.
